// File: rtl/bus_driver_arbiter_pkg.sv
// Shared types and helpers for the tristate bus arbiter.
package bus_driver_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN  = 2'b01,
    GAP  = 2'b10
  } arb_state_e;

  // Ceiling log2; clog2(1) is 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        res = res + 1;
        v   = v >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_driver_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate so rr_ptr sits at bit 0, take the
// lowest set bit, then rotate the index back.
module bus_driver_arbiter_rr_picker
  import bus_driver_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [ID_W-1:0]    win_idx,
  output logic               any_req
);

  logic [NUM_REQ-1:0] req_rot;
  logic [ID_W-1:0]    rot_idx;
  logic [ID_W:0]      idx_sum;

  // Double-width rotate, priority encode, then map back modulo NUM_REQ.
  always_comb begin
    req_rot = NUM_REQ'({req, req} >> rr_ptr);
    rot_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_idx = ID_W'(i);
    end
    idx_sum = {1'b0, rot_idx} + {1'b0, rr_ptr};
    if (idx_sum >= (ID_W + 1)'(NUM_REQ)) idx_sum = idx_sum - (ID_W + 1)'(NUM_REQ);
    win_idx = idx_sum[ID_W-1:0];
    any_req = |req;
    win_oh  = any_req ? (NUM_REQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/bus_driver_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus with hold limit and
// a forced all-off turnaround gap between owners.
module bus_driver_arbiter
  import bus_driver_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAX_HOLD    = 4,
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned ID_W        = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] drv_en,
  output logic [ID_W-1:0]    owner_id,
  output logic               bus_busy
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;
  localparam int unsigned GAP_W  = (TURN_CYCLES > 1) ? clog2(TURN_CYCLES) : 1;

  arb_state_e         state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [NUM_REQ-1:0] drv_en_nxt;
  logic [ID_W-1:0]    owner_id_nxt;
  logic               bus_busy_nxt;

  logic [NUM_REQ-1:0] win_oh;
  logic [ID_W-1:0]    win_idx;
  logic               any_req;
  logic               release_c;

  bus_driver_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  // State and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      drv_en   <= '0;
      owner_id <= '0;
      bus_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      drv_en   <= drv_en_nxt;
      owner_id <= owner_id_nxt;
      bus_busy <= bus_busy_nxt;
    end
  end

  // Next-state and next-output logic. In OWN, drv_en is onehot(owner), so
  // req & ~drv_en is the set of other waiting requesters.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    hold_cnt_nxt = hold_cnt;
    gap_cnt_nxt  = gap_cnt;
    drv_en_nxt   = drv_en;
    owner_id_nxt = owner_id;
    release_c    = !req[owner_id] ||
                   ((hold_cnt == HOLD_W'(MAX_HOLD - 1)) && ((req & ~drv_en) != '0));

    case (state)
      IDLE: begin
        drv_en_nxt   = '0;
        owner_id_nxt = '0;
        if (any_req) begin
          drv_en_nxt   = win_oh;
          owner_id_nxt = win_idx;
          hold_cnt_nxt = '0;
          state_nxt    = OWN;
        end
      end
      OWN: begin
        if (release_c) begin
          drv_en_nxt  = '0;
          rr_ptr_nxt  = (owner_id == ID_W'(NUM_REQ - 1)) ? '0 : owner_id + ID_W'(1);
          gap_cnt_nxt = '0;
          state_nxt   = GAP;
        end else if (hold_cnt != HOLD_W'(MAX_HOLD - 1)) begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      GAP: begin
        drv_en_nxt = '0;
        if (gap_cnt == GAP_W'(TURN_CYCLES - 1)) begin
          owner_id_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        drv_en_nxt   = '0;
        owner_id_nxt = '0;
        state_nxt    = IDLE;
      end
    endcase

    bus_busy_nxt = |drv_en_nxt;
  end

endmodule

// File: doc/bus_driver_arbiter.md
Name: bus_driver_arbiter

Overview:
- Arbitrates ownership of a shared tristate data bus between NUM_REQ requesters.
- Each requester drives the bus through its own tristate buffer. This block generates the one-hot data_en vector for those buffers.
- Allocation is round-robin with a per-owner hold limit.
- A forced all-off turnaround gap between owners guarantees no two buffers ever drive the bus together.

Parameters:
- NUM_REQ, 4, number of requesters/tristate drivers (2..8).
- MAX_HOLD, 4, max consecutive cycles an owner keeps the bus while another requester waits (>=1).
- TURN_CYCLES, 1, all-drivers-off cycles between release and next grant (>=1).
- ID_W, 2, width of owner_id; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- req  input  NUM_REQ  per-requester bus request; level, held while the bus is wanted.
- drv_en  output  NUM_REQ  registered one-hot (or zero) enables to the tristate buffers' data_en.
- owner_id  output  ID_W  index of the current owner; 0 when idle.
- bus_busy  output  1  high while any drv_en bit is high.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset: sampled rst_n=0 at a rising edge forces the following, regardless of req:
  - state=IDLE, drv_en=0, owner_id=0, bus_busy=0.
  - rr_ptr=0, hold_cnt=0, gap_cnt=0.
- Outputs: all are registered; no combinational path from req to drv_en.
- Invariant: popcount(drv_en) <= 1 in every cycle, including reset exit.
- States:
  - IDLE: if req!=0 at an edge, choose a winner by rotating priority starting at rr_ptr (rr_ptr highest, then rr_ptr+1 ... wrapping modulo NUM_REQ).
    - Next cycle: drv_en=onehot(winner), owner_id=winner, hold_cnt=0, state=OWN.
    - If req==0: stay in IDLE.
    - Latency from req to drv_en is 1 cycle.
  - OWN: at each edge, hold_cnt increments (saturating at MAX_HOLD-1). Release condition:
    - (a) req[owner]==0, or
    - (b) hold_cnt==MAX_HOLD-1 and (req & ~onehot(owner))!=0.
    - On release, next cycle: drv_en=0, bus_busy=0, rr_ptr=(owner+1) mod NUM_REQ, gap_cnt=0, state=GAP.
    - owner_id keeps the last owner through GAP and returns to 0 in IDLE.
    - A lone requester is never forced off; it keeps the bus as long as req stays high.
  - GAP: drv_en=0 for exactly TURN_CYCLES cycles.
    - gap_cnt counts 0..TURN_CYCLES-1, then state goes to IDLE.
    - req is ignored during GAP.
- Resulting timing: minimum spacing between two owners is TURN_CYCLES+1 zero cycles (GAP, then the IDLE arbitration cycle).
- Boundary conditions:
  - Owner drops req in the same cycle another raises req: release via (a); the new requester is served after the gap.
  - Owner drops req and the hold limit is reached at the same edge: single release, same behaviour.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Requests arriving during GAP are latched only by being held; pulses that end inside GAP are lost (requests are level-based by contract).
  - Reset mid-OWN or mid-GAP: drv_en drops to 0 at that edge and arbitration restarts at rr_ptr=0.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE=2'b00, OWN=2'b01, GAP=2'b10.
  - the clog2 helper function used to derive ID_W.
- One natural sub-module: rr_picker. It is combinational: req vector + rr_ptr in, one-hot winner + winner index + any_req out, using a double-width rotate-and-priority scheme.

Test Plan:
- Reset: rst_n=0 for 2 edges with req=4'b1111 -> drv_en=0000, bus_busy=0, owner_id=0. First edge after rst_n=1 -> drv_en=0001.
- Single requester: req=0010 sampled at edge 1 -> drv_en=0010, owner_id=1 after edge 1. Drop req before edge 5 -> drv_en=0000 after edge 5, then 1 GAP cycle, then IDLE.
- Round robin under full load: req=1111 held -> drv_en sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 4 cycles, separated by 2 zero cycles (GAP + IDLE).
- Lone long holder: req=0100 held 12 cycles with no other requests -> drv_en=0100 continuously, no forced release. Raise req[0] at cycle 12 -> release after hold_cnt==3 is reached; next owner is 0001.
- Handover race: owner 3 drops req in the same cycle req[1] rises -> drv_en 1000 -> 0000 for 2 cycles -> 0010. Assertion popcount(drv_en)<=1 checked every cycle.
- Reset mid-ownership: drv_en=1000, assert rst_n=0 for 1 edge -> drv_en=0000 at that edge. Release reset with req=1001 -> drv_en=0001 (rr_ptr back to 0).
